// File: rtl/mem_io_bridge_pkg.sv
// Shared I/O page map for mem_io_bridge: register indices, STATUS layout and
// a helper that packs the STATUS word.
package mem_io_bridge_pkg;

  localparam logic [3:0] IO_PAGE_DEF = 4'hF;

  typedef enum logic [3:0] {
    REG_TXDATA = 4'h0,
    REG_STATUS = 4'h1,
    REG_CYC_LO = 4'h2,
    REG_CYC_HI = 4'h3,
    REG_LED    = 4'h4
  } io_reg_e;

  localparam int STAT_OVF   = 15;
  localparam int STAT_FULL  = 8;
  localparam int STAT_EMPTY = 7;

  typedef struct packed {
    logic       ovf;
    logic       full;
    logic       empty;
    logic [3:0] count;
  } tx_status_t;

  function automatic logic [15:0] status_word(input tx_status_t s);
    logic [15:0] w;
    w             = '0;
    w[STAT_OVF]   = s.ovf;
    w[STAT_FULL]  = s.full;
    w[STAT_EMPTY] = s.empty;
    w[3:0]        = s.count;
    return w;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU memory port, external RAM port and TX stream of mem_io_bridge in one bundle.
// The bridge uses the slave modport; whoever plays CPU + RAM + consumer uses master.
interface mem_io_bridge_if;
  logic [15:0] cpu_raddr_i;
  logic        cpu_rd_i;
  logic [15:0] cpu_rdata_o;
  logic [15:0] cpu_waddr_i;
  logic [15:0] cpu_wdata_i;
  logic        cpu_wr_i;
  logic [15:0] ram_raddr_o;
  logic        ram_rd_o;
  logic [15:0] ram_rdata_i;
  logic [15:0] ram_waddr_o;
  logic [15:0] ram_wdata_o;
  logic        ram_wr_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [15:0] led_o;

  modport slave (
    input  cpu_raddr_i, cpu_rd_i, cpu_waddr_i, cpu_wdata_i, cpu_wr_i,
    input  ram_rdata_i, tx_ready_i,
    output cpu_rdata_o, ram_raddr_o, ram_rd_o, ram_waddr_o, ram_wdata_o, ram_wr_o,
    output tx_data_o, tx_valid_o, led_o
  );

  modport master (
    output cpu_raddr_i, cpu_rd_i, cpu_waddr_i, cpu_wdata_i, cpu_wr_i,
    output ram_rdata_i, tx_ready_i,
    input  cpu_rdata_o, ram_raddr_o, ram_rd_o, ram_waddr_o, ram_wdata_o, ram_wr_o,
    input  tx_data_o, tx_valid_o, led_o
  );
endinterface

// File: rtl/mem_io_bridge_fifo.sv
// Synchronous circular-buffer FIFO with separate occupancy count; head is
// shown combinationally and forced to zero while empty.
module sync_fifo #(
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mem_io_bridge.sv
// Splits CPU accesses between external block RAM and a 16-word I/O page
// (TX FIFO, cycle counter snapshot, LEDs) with uniform 1-cycle read latency.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int         TXDEPTH = 8,
  parameter logic [3:0] IO_PAGE = IO_PAGE_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_io_bridge_if.slave  bus
);

  localparam int CW = $clog2(TXDEPTH + 1);

  logic          io_read, io_write;
  logic [3:0]    ridx, widx;
  logic          tx_wr, push, pop, ovf_set, ovf_clr, snap_wr, led_wr;
  logic          tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic [7:0]    tx_head;
  logic          ovf_q;
  logic [31:0]   cyc_q, snap_q;
  logic [15:0]   led_q;
  logic          sel_io_q;
  logic [15:0]   io_rdata, io_rdata_q;
  logic [3:0]    cnt4;
  tx_status_t    stat;

  assign io_read  = (bus.cpu_raddr_i[15:12] == IO_PAGE);
  assign io_write = (bus.cpu_waddr_i[15:12] == IO_PAGE);
  assign ridx     = bus.cpu_raddr_i[3:0];
  assign widx     = bus.cpu_waddr_i[3:0];

  assign bus.ram_raddr_o = bus.cpu_raddr_i;
  assign bus.ram_rd_o    = bus.cpu_rd_i & ~io_read;
  assign bus.ram_waddr_o = bus.cpu_waddr_i;
  assign bus.ram_wdata_o = bus.cpu_wdata_i;
  assign bus.ram_wr_o    = bus.cpu_wr_i & ~io_write;

  assign tx_wr   = bus.cpu_wr_i & io_write & (widx == REG_TXDATA);
  assign snap_wr = bus.cpu_wr_i & io_write & (widx == REG_CYC_LO);
  assign led_wr  = bus.cpu_wr_i & io_write & (widx == REG_LED);
  assign ovf_clr = bus.cpu_wr_i & io_write & (widx == REG_STATUS) & bus.cpu_wdata_i[STAT_OVF];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop     = ~tx_empty & bus.tx_ready_i;
  assign push    = tx_wr & (~tx_full | pop);
  assign ovf_set = tx_wr & tx_full & ~pop;

  sync_fifo #(.DWIDTH(8), .DEPTH(TXDEPTH)) u_txq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.cpu_wdata_i[7:0]),
    .rdata   (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  assign bus.tx_data_o  = tx_head;
  assign bus.tx_valid_o = ~tx_empty;
  assign bus.led_o      = led_q;

  generate
    if (CW >= 4) begin : g_cnt_trunc
      assign cnt4 = tx_count[3:0];
    end else begin : g_cnt_ext
      assign cnt4 = 4'(tx_count);
    end
  endgenerate

  assign stat = '{ovf: ovf_q, full: tx_full, empty: tx_empty, count: cnt4};

  always_comb begin
    io_rdata = '0;
    case (ridx)
      REG_STATUS: io_rdata = status_word(stat);
      REG_CYC_LO: io_rdata = snap_q[15:0];
      REG_CYC_HI: io_rdata = snap_q[31:16];
      REG_LED:    io_rdata = led_q;
      default:    io_rdata = '0;
    endcase
  end

  // Overflow set wins over a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q      <= 1'b0;
      cyc_q      <= '0;
      snap_q     <= '0;
      led_q      <= '0;
      sel_io_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      cyc_q      <= cyc_q + 32'd1;
      sel_io_q   <= io_read;
      io_rdata_q <= io_rdata;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (snap_wr) snap_q <= cyc_q;
      if (led_wr)  led_q  <= bus.cpu_wdata_i;
    end
  end

  assign bus.cpu_rdata_o = sel_io_q ? io_rdata_q : bus.ram_rdata_i;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: decode/read-latency vector table plus
// hand sequences for FIFO, overflow, counter snapshot and async reset.
module tb_mem_io_bridge;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  mem_io_bridge_if bus();

  mem_io_bridge #(.TXDEPTH(8), .IO_PAGE(4'hF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, 1024 words, preset to a known pattern on reset.
  logic [15:0] ram [1024];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ram_rdata_i <= '0;
      for (int i = 0; i < 1024; i++) ram[i] <= 16'hA500 | 16'(i[7:0]);
    end else begin
      if (bus.ram_wr_o) ram[bus.ram_waddr_o[9:0]] <= bus.ram_wdata_o;
      if (bus.ram_rd_o) bus.ram_rdata_i <= ram[bus.ram_raddr_o[9:0]];
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic [15:0] exp_rdata;
    logic [15:0] exp_led;
    logic        exp_ram_wr;
    logic        exp_ram_rd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cpu_waddr_i = a;
    bus.cpu_wdata_i = d;
    bus.cpu_wr_i    = 1'b1;
    @(negedge clk);
    bus.cpu_wr_i    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.cpu_raddr_i = a;
    @(posedge clk);
    #1 d = bus.cpu_rdata_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d, lo, lo2;

    bus.cpu_raddr_i = '0;
    bus.cpu_rd_i    = 1'b1;
    bus.cpu_waddr_i = '0;
    bus.cpu_wdata_i = '0;
    bus.cpu_wr_i    = 1'b0;
    bus.tx_ready_i  = 1'b0;

    // wr, waddr, wdata, raddr, exp_rdata, exp_led, exp_ram_wr, exp_ram_rd
    vecs[0]  = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 16'hA500, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h0100, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 16'hF004, 16'hBEEF, 16'h0005, 16'hA505, 16'hBEEF, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 16'hF004, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 16'hF7F4, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'hF001, 16'h0080, 16'hBEEF, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'hF009, 16'hFFFF, 16'hF009, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'hF7F3, 16'h1111, 16'hF000, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'hF004, 16'h00FF, 16'hF004, 16'hBEEF, 16'h00FF, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'hF004, 16'h0001, 16'hF004, 16'h00FF, 16'h0001, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 16'hF004, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'hE004, 16'h7777, 16'hF004, 16'h0001, 16'h0001, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 16'h0000, 16'h0004, 16'h7777, 16'h0001, 1'b0, 1'b1};

    // Reset state
    #3 reset_n = 1'b0;
    #1;
    chk("rst tx_valid", bus.tx_valid_o, 0);
    chk("rst tx_data", bus.tx_data_o, 0);
    chk("rst led", bus.led_o, 0);
    chk("rst rdata", bus.cpu_rdata_o, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Decode and read-latency table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.cpu_wr_i    = vecs[i].wr;
      bus.cpu_waddr_i = vecs[i].waddr;
      bus.cpu_wdata_i = vecs[i].wdata;
      bus.cpu_raddr_i = vecs[i].raddr;
      #1;
      chk($sformatf("v%0d ram_wr", i), bus.ram_wr_o, vecs[i].exp_ram_wr);
      chk($sformatf("v%0d ram_rd", i), bus.ram_rd_o, vecs[i].exp_ram_rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rdata", i), bus.cpu_rdata_o, vecs[i].exp_rdata);
      chk($sformatf("v%0d led", i), bus.led_o, vecs[i].exp_led);
    end
    @(negedge clk);
    bus.cpu_wr_i = 1'b0;

    // FIFO fill beyond capacity, then drain
    for (int i = 0; i < 9; i++) io_wr(16'hF000, 16'h0041 + 16'(i));
    rd(16'hF001, d);
    chk("fill status", d, 16'h8108);
    @(negedge clk);
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d valid", i), bus.tx_valid_o, 1);
      chk($sformatf("drain%0d data", i), bus.tx_data_o, 32'h41 + 32'(i));
      @(negedge clk);
    end
    chk("drained valid", bus.tx_valid_o, 0);
    bus.tx_ready_i = 1'b0;
    rd(16'hF001, d);
    chk("empty ovf status", d, 16'h8080);
    io_wr(16'hF001, 16'h8000);
    rd(16'hF001, d);
    chk("ovf cleared status", d, 16'h0080);

    // Push into a full FIFO while the head pops
    for (int i = 0; i < 8; i++) io_wr(16'hF000, 16'h0061 + 16'(i));
    @(negedge clk);
    bus.tx_ready_i  = 1'b1;
    bus.cpu_waddr_i = 16'hF000;
    bus.cpu_wdata_i = 16'h0055;
    bus.cpu_wr_i    = 1'b1;
    @(negedge clk);
    bus.cpu_wr_i   = 1'b0;
    bus.tx_ready_i = 1'b0;
    rd(16'hF001, d);
    chk("full+pop status", d, 16'h0108);
    @(negedge clk);
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fp%0d data", i), bus.tx_data_o, (i < 7) ? 32'h62 + 32'(i) : 32'h55);
      @(negedge clk);
    end
    chk("fp drained valid", bus.tx_valid_o, 0);
    bus.tx_ready_i = 1'b0;

    // Async reset with bytes queued
    for (int i = 0; i < 3; i++) io_wr(16'hF000, 16'h0001 + 16'(i));
    io_wr(16'hF004, 16'h00A5);
    rd(16'hF004, d);
    chk("pre-reset led read", d, 16'h00A5);
    chk("pre-reset valid", bus.tx_valid_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst valid", bus.tx_valid_o, 0);
    chk("async rst led", bus.led_o, 0);
    chk("async rst rdata", bus.cpu_rdata_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(16'hF001, d);
    chk("post-reset status", d, 16'h0080);

    // Counter snapshot about 100 cycles after reset release
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (99) @(negedge clk);
    io_wr(16'hF002, 16'h0000);
    rd(16'hF002, lo);
    total++;
    if (lo < 16'd99 || lo > 16'd101) begin
      bad++;
      $display("FAIL snap lo: got=%0d expected=99..101", lo);
    end
    rd(16'hF003, d);
    chk("snap hi", d, 0);
    repeat (5) @(negedge clk);
    rd(16'hF002, lo2);
    chk("snap lo stable", lo2, lo);

    // Counter forced to the top value, snapshot before and after wrap
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cyc_q;
    bus.cpu_waddr_i = 16'hF002;
    bus.cpu_wr_i    = 1'b1;
    @(negedge clk);
    bus.cpu_wr_i = 1'b0;
    rd(16'hF003, d);
    chk("top snap hi", d, 16'hFFFF);
    rd(16'hF002, d);
    chk("top snap lo", d, 16'hFFFF);
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cyc_q;
    @(negedge clk);
    bus.cpu_waddr_i = 16'hF002;
    bus.cpu_wr_i    = 1'b1;
    @(negedge clk);
    bus.cpu_wr_i = 1'b0;
    rd(16'hF002, d);
    chk("wrap snap lo", d, 0);
    rd(16'hF003, d);
    chk("wrap snap hi", d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
